// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module   : pc_fetch_unit_if
// Brief    : Handshake bundle between the condition/hazard logic and the
//            PC/fetch-redirect stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              jmpR;
  logic [ADDR_W-1:0] jmpTarget;
  logic              stall;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pcPlus;
  logic              fetchValid;
  logic              flush;

  modport master (
    output jmpR, jmpTarget, stall,
    input  pc, pcPlus, fetchValid, flush
  );

  modport slave (
    input  jmpR, jmpTarget, stall,
    output pc, pcPlus, fetchValid, flush
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Owns the PC, sequences fetch addresses, redirects on taken jumps
//            and squashes wrong-path IF/ID contents for a fixed flush window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 2
) (
  input  wire logic      clk,
  input  wire logic      rst,
  pc_fetch_unit_if.slave bus
);

  localparam int                CNT_W      = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD_JMP = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] tgt_aligned;
  logic [ADDR_W-1:0] pc_plus;

  assign tgt_aligned = bus.jmpTarget & ALIGN_MASK;
  assign pc_plus     = pc_q + STEP;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.jmpR) begin
          // A jump seen under stall is parked rather than dropped.
          if (bus.stall) begin
            pend_d  = tgt_aligned;
            state_d = HOLD_JMP;
          end else begin
            pc_d    = tgt_aligned;
            cnt_d   = CNT_LOAD;
            state_d = FLUSH;
          end
        end else if (!bus.stall) begin
          pc_d = pc_plus;
        end
      end
      HOLD_JMP: begin
        if (!bus.stall) begin
          pc_d    = pend_q;
          cnt_d   = CNT_LOAD;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pc_d  = pc_plus;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Status outputs are forced low while reset is asserted, independent of state.
  assign bus.pc         = pc_q;
  assign bus.pcPlus     = pc_plus;
  assign bus.flush      = rst && ((state_q == FLUSH) || (state_q == HOLD_JMP));
  assign bus.fetchValid = rst && (state_q == RUN) && !bus.stall;

endmodule

`default_nettype wire
